// File: rtl/actuator_interlock_if.sv
// actuator_interlock_if
// Request/drive bundle between the wash program processor (master) and the
// actuator interlock (slave).
//
// Signalling: this bundle has no valid/ready handshake. Every req_* line is
// a level that the master holds for as long as the actuator should run. The
// slave samples the requests on each rising clock edge and answers one cycle
// later with registered drive levels. estop is a level. fault_clr is a
// single-cycle pulse. motor_state mirrors the motor FSM encoding and is for
// observation only (0 idle, 1 forward, 2 reverse, 3 brake).
interface actuator_interlock_if;
    logic       req_fill;
    logic       req_release;
    logic       req_fwd;
    logic       req_rev;
    logic       estop;
    logic       fault_clr;

    logic       valve_fill;
    logic       valve_release;
    logic       motor_fwd;
    logic       motor_rev;
    logic       door_lock;
    logic       motor_busy;
    logic       fault;
    logic [1:0] motor_state;

    modport master (
        output req_fill,
        output req_release,
        output req_fwd,
        output req_rev,
        output estop,
        output fault_clr,
        input  valve_fill,
        input  valve_release,
        input  motor_fwd,
        input  motor_rev,
        input  door_lock,
        input  motor_busy,
        input  fault,
        input  motor_state
    );

    modport slave (
        input  req_fill,
        input  req_release,
        input  req_fwd,
        input  req_rev,
        input  estop,
        input  fault_clr,
        output valve_fill,
        output valve_release,
        output motor_fwd,
        output motor_rev,
        output door_lock,
        output motor_busy,
        output fault,
        output motor_state
    );
endinterface

// File: rtl/actuator_interlock.sv
// actuator_interlock
// Safety sequencer between the wash program processor's actuator strobes and
// the physical drivers. It forces a motor dead time on every stop or
// direction change, lets the drain valve win over the fill valve, holds the
// door lock for a while after everything goes idle, and latches a sticky
// fault on emergency stop.
//
// Optional feature: define MOTOR_TIMEOUT_EN to add a continuous-run limit
// (MAX_RUN_CYCLES) on each motor direction; expiry raises the sticky fault.
// Without the macro the motor may run indefinitely and only estop faults.
//
// All outputs are registered; requests sampled on an edge show up on the
// drives right after that edge.
module actuator_interlock #(
    parameter int CNT_WIDTH      = 16,
    parameter int DEAD_CYCLES    = 16,
    parameter int UNLOCK_CYCLES  = 64,
    parameter int MAX_RUN_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    actuator_interlock_if.slave  bus
);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_FWD   = 2'd1,
        M_REV   = 2'd2,
        M_BRAKE = 2'd3
    } motor_state_t;

    // Dead counter is loaded with DEAD_CYCLES-1 because the brake cycle that
    // sees the counter at zero is itself still a motor-off cycle.
    localparam logic [CNT_WIDTH-1:0] DEAD_LOAD   = CNT_WIDTH'(DEAD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LOAD = CNT_WIDTH'(UNLOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    motor_state_t         state;
    logic [CNT_WIDTH-1:0] dead_cnt;
    logic [CNT_WIDTH-1:0] unlock_cnt;

    logic valve_fill_q;
    logic valve_release_q;
    logic motor_fwd_q;
    logic motor_rev_q;
    logic motor_busy_q;
    logic door_lock_q;
    logic fault_q;

    logic want_fwd;
    logic want_rev;
    logic running;
    logic timeout;
    logic fault_set;
    logic fault_next;
    logic inhibit;
    logic start_fwd;
    logic start_rev;
    logic valve_fill_next;
    logic valve_release_next;
    logic lock_active;

    // Both direction requests at once are treated as no request at all.
    assign want_fwd = bus.req_fwd & ~bus.req_rev;
    assign want_rev = bus.req_rev & ~bus.req_fwd;
    assign running  = (state == M_FWD) || (state == M_REV);

`ifdef MOTOR_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(MAX_RUN_CYCLES - 1);

    logic [CNT_WIDTH-1:0] run_cnt;

    // Trips on the last allowed run cycle so the fault and the brake land on
    // the following edge.
    assign timeout = running && (run_cnt == RUN_LAST);

    // Continuous-run counter: counts while driving, clears whenever not.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (running) begin
            if (run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end
`else
    // The run limit has no effect in this build.
    logic unused_run_limit;
    assign unused_run_limit = (MAX_RUN_CYCLES > 0);
    assign timeout          = 1'b0;
`endif

    // A fault being raised this edge already blocks valves and motor, so the
    // drives drop on the same edge that fault goes high.
    assign fault_set = bus.estop | timeout;
    assign inhibit   = fault_q | fault_set;

    // Clearing needs estop low (implied by !fault_set) and a parked motor;
    // fault_clr during braking or while estop is held is simply ignored.
    assign fault_next = fault_set | (fault_q & ~(bus.fault_clr & (state == M_IDLE)));

    assign start_fwd = want_fwd & ~inhibit;
    assign start_rev = want_rev & ~inhibit;

    // Drain has priority over fill; a fault closes both valves.
    assign valve_release_next = bus.req_release & ~inhibit;
    assign valve_fill_next    = bus.req_fill & ~bus.req_release & ~inhibit;

    // The door stays locked while anything moves or a fault is pending.
    assign lock_active = (state != M_IDLE) | valve_fill_next | valve_release_next | fault_next;

    // Motor FSM: dead time on every stop/reversal, brake exits only to idle
    // while a fault is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= M_IDLE;
            dead_cnt     <= '0;
            motor_fwd_q  <= 1'b0;
            motor_rev_q  <= 1'b0;
            motor_busy_q <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (start_fwd) begin
                        state        <= M_FWD;
                        motor_fwd_q  <= 1'b1;
                        motor_busy_q <= 1'b1;
                    end else if (start_rev) begin
                        state        <= M_REV;
                        motor_rev_q  <= 1'b1;
                        motor_busy_q <= 1'b1;
                    end
                end
                M_FWD: begin
                    if (inhibit || !want_fwd) begin
                        state       <= M_BRAKE;
                        dead_cnt    <= DEAD_LOAD;
                        motor_fwd_q <= 1'b0;
                    end
                end
                M_REV: begin
                    if (inhibit || !want_rev) begin
                        state       <= M_BRAKE;
                        dead_cnt    <= DEAD_LOAD;
                        motor_rev_q <= 1'b0;
                    end
                end
                M_BRAKE: begin
                    if (dead_cnt != '0) begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end else if (start_fwd) begin
                        state       <= M_FWD;
                        motor_fwd_q <= 1'b1;
                    end else if (start_rev) begin
                        state       <= M_REV;
                        motor_rev_q <= 1'b1;
                    end else begin
                        state        <= M_IDLE;
                        motor_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= M_IDLE;
                    dead_cnt     <= '0;
                    motor_fwd_q  <= 1'b0;
                    motor_rev_q  <= 1'b0;
                    motor_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Valve drives and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valve_fill_q    <= 1'b0;
            valve_release_q <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            valve_fill_q    <= valve_fill_next;
            valve_release_q <= valve_release_next;
            fault_q         <= fault_next;
        end
    end

    // Door lock: reload the hold while active, then count down so the lock
    // drops exactly UNLOCK_CYCLES edges after the last active edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            door_lock_q <= 1'b0;
            unlock_cnt  <= '0;
        end else if (lock_active) begin
            door_lock_q <= 1'b1;
            unlock_cnt  <= UNLOCK_LOAD;
        end else begin
            door_lock_q <= (unlock_cnt > CNT_ONE);
            if (unlock_cnt != '0) begin
                unlock_cnt <= unlock_cnt - 1'b1;
            end
        end
    end

    assign bus.valve_fill    = valve_fill_q;
    assign bus.valve_release = valve_release_q;
    assign bus.motor_fwd     = motor_fwd_q;
    assign bus.motor_rev     = motor_rev_q;
    assign bus.door_lock     = door_lock_q;
    assign bus.motor_busy    = motor_busy_q;
    assign bus.fault         = fault_q;
    assign bus.motor_state   = state;

endmodule

// File: tb/tb_actuator_interlock.sv
// tb_actuator_interlock
// Cycle reference model feeds an expected queue on every rising edge; the
// DUT drives are popped and compared on the falling edge. Directed
// scenarios add timing checks measured straight from the drive waveforms.
module tb_actuator_interlock;

    localparam int DEAD   = 4;
    localparam int UNLOCK = 8;
    localparam int MAXRUN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    actuator_interlock_if bus ();

    actuator_interlock #(
        .CNT_WIDTH      (16),
        .DEAD_CYCLES    (DEAD),
        .UNLOCK_CYCLES  (UNLOCK),
        .MAX_RUN_CYCLES (MAXRUN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 forward, 2 reverse, 3 motor off.
    logic [6:0] exp_q[$];
    int m_mode = 0;
    int m_off = 0;
    int m_run = 0;
    int m_hold = 0;
    bit m_fault = 1'b0;

    always @(posedge clk) begin
        int  mode_n, off_n, run_n, hold_n;
        bit  fault_n, vf_n, vr_n, lock_n, tmo, stop, go_f, go_r;
        go_f = bus.req_fwd && !bus.req_rev;
        go_r = bus.req_rev && !bus.req_fwd;
        tmo  = 1'b0;
`ifdef MOTOR_TIMEOUT_EN
        tmo = (m_mode == 1 || m_mode == 2) && (m_run == MAXRUN - 1);
`endif
        stop    = m_fault || bus.estop || tmo;
        fault_n = bus.estop || tmo || (m_fault && !(bus.fault_clr && m_mode == 0));
        vr_n    = bus.req_release && !stop;
        vf_n    = bus.req_fill && !bus.req_release && !stop;
        mode_n  = m_mode;
        off_n   = m_off;
        if (m_mode == 3 && m_off > 0) begin
            off_n = m_off - 1;
        end else if (m_mode == 0 || m_mode == 3) begin
            mode_n = stop ? 0 : (go_f ? 1 : (go_r ? 2 : 0));
        end else if (stop || !(m_mode == 1 ? go_f : go_r)) begin
            mode_n = 3;
            off_n  = DEAD - 1;
        end
        run_n = (m_mode == 1 || m_mode == 2) ? m_run + 1 : 0;
        if (m_mode != 0 || vf_n || vr_n || fault_n) begin
            lock_n = 1'b1;
            hold_n = UNLOCK;
        end else begin
            lock_n = (m_hold > 1);
            hold_n = (m_hold > 0) ? m_hold - 1 : 0;
        end
        if (rst) begin
            mode_n = 0; off_n = 0; run_n = 0; hold_n = 0;
            fault_n = 1'b0; vf_n = 1'b0; vr_n = 1'b0; lock_n = 1'b0;
        end
        m_mode  <= mode_n;
        m_off   <= off_n;
        m_run   <= run_n;
        m_hold  <= hold_n;
        m_fault <= fault_n;
        exp_q.push_back({vf_n, vr_n, mode_n == 1, mode_n == 2, lock_n, mode_n != 0, fault_n});
    end

    // Scoreboard: compare every cycle, and the two motor drives are exclusive.
    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", 32'({bus.valve_fill, bus.valve_release, bus.motor_fwd, bus.motor_rev,
                                  bus.door_lock, bus.motor_busy, bus.fault}), 32'(e));
            check("motor_exclusive", 32'(bus.motor_fwd & bus.motor_rev), 0);
        end
    end

    // Driver tasks
    task automatic drive(input bit f, input bit r, input bit fw, input bit rv,
                         input bit es, input bit clr);
        bus.req_fill    = f;
        bus.req_release = r;
        bus.req_fwd     = fw;
        bus.req_rev     = rv;
        bus.estop       = es;
        bus.fault_clr   = clr;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int lcnt;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        wait_cycles(3);
        check("reset_state", 32'({bus.valve_fill, bus.valve_release, bus.motor_fwd, bus.motor_rev,
                                  bus.door_lock, bus.motor_busy, bus.fault}), 0);
        rst = 1'b0;
        wait_cycles(2);

        // Forward for 10 cycles, then reverse: exactly DEAD off cycles between.
        drive(0, 0, 1, 0, 0, 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.motor_fwd) cnt++;
        end
        check("fwd_cycles", 32'(cnt), 10);
        drive(0, 0, 0, 1, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20 && !bus.motor_rev; i++) begin
            @(negedge clk);
            if (!bus.motor_fwd && !bus.motor_rev) cnt++;
        end
        check("dead_time", 32'(cnt), DEAD);
        check("rev_running", 32'(bus.motor_rev), 1);
        wait_cycles(3);

        // Drop everything: busy for the dead time, lock for dead time + hold.
        drive(0, 0, 0, 0, 0, 0);
        cnt = 0;
        lcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.motor_busy) cnt++;
            if (!bus.door_lock) break;
            lcnt++;
        end
        check("busy_tail", 32'(cnt), DEAD);
        check("lock_after_motor", 32'(lcnt), DEAD + UNLOCK);
        wait_cycles(2);

        // Fill and drain together: drain wins; dropping drain lets fill through.
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("drain_wins", 32'({bus.valve_fill, bus.valve_release}), 32'b01);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fill_after_drain", 32'({bus.valve_fill, bus.valve_release}), 32'b10);
        wait_cycles(2);

        // The edge sampling the drop is the first idle one; the last active
        // edge precedes it, so the lock stays up UNLOCK-1 more cycles.
        drive(0, 0, 0, 0, 0, 0);
        lcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.door_lock) break;
            lcnt++;
        end
        check("lock_hold", 32'(lcnt), UNLOCK - 1);
        wait_cycles(2);

        // Emergency stop while running forward with the fill valve open.
        drive(1, 0, 1, 0, 0, 0);
        wait_cycles(5);
        drive(1, 0, 1, 0, 1, 0);
        @(negedge clk);
        check("estop_effect", 32'({bus.fault, bus.valve_fill, bus.valve_release,
                                   bus.motor_fwd, bus.motor_rev}), 32'b10000);
        drive(1, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("clr_in_brake", 32'(bus.fault), 1);
        drive(1, 0, 1, 0, 0, 0);
        cnt = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.motor_busy) break;
            cnt++;
        end
        check("fault_brake_len", 32'(cnt), DEAD);
        wait_cycles(3);
        check("ignored_in_fault", 32'({bus.motor_fwd, bus.valve_fill, bus.door_lock, bus.fault}),
              32'b0011);
        drive(1, 0, 1, 0, 1, 1);
        @(negedge clk);
        check("clr_with_estop", 32'(bus.fault), 1);
        drive(1, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("fault_clear", 32'(bus.fault), 0);
        drive(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("resume_after_clear", 32'({bus.motor_fwd, bus.valve_fill}), 32'b11);
        wait_cycles(3);

        // Reset mid-run drops every drive on the next edge.
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_run", 32'({bus.valve_fill, bus.valve_release, bus.motor_fwd, bus.motor_rev,
                                    bus.door_lock, bus.motor_busy, bus.fault}), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        wait_cycles(3);

        // Long forward run: limited to MAXRUN cycles only with the timeout.
        drive(0, 0, 1, 0, 0, 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.motor_fwd) cnt++;
        end
`ifdef MOTOR_TIMEOUT_EN
        check("run_cycles", 32'(cnt), MAXRUN);
        check("timeout_fault", 32'(bus.fault), 1);
`else
        check("run_cycles", 32'(cnt), 40);
        check("timeout_fault", 32'(bus.fault), 0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        wait_cycles(8);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("idle_no_fault", 32'(bus.fault), 0);
        wait_cycles(2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0));
            wait_cycles($urandom_range(1, 6));
        end
        drive(0, 0, 0, 0, 0, 0);
        wait_cycles(20);
        drive(0, 0, 0, 0, 0, 1);
        wait_cycles(1);
        drive(0, 0, 0, 0, 0, 0);
        wait_cycles(UNLOCK + 4);
        check("final_idle", 32'({bus.door_lock, bus.motor_busy, bus.fault}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
